// File: rtl/bist_ctrl.sv
// BIST sequencer: seeds the LFSR, clears the SISR, clocks N_PAT patterns,
// then compares the SISR signature against GOLDEN and keeps a saturating fail tally.
module bist_ctrl #(
  parameter int               N_PAT  = 31,
  parameter int               SIG_W  = 4,
  parameter logic [SIG_W-1:0] GOLDEN = SIG_W'(4'hA)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] sig_in,
  output logic             seed_ld,
  output logic             sisr_clr,
  output logic             lfsr_en,
  output logic             sisr_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [7:0]       pat_cnt,
  output logic [7:0]       fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   pat_last;

  assign pat_last = (pat_cnt == 8'(N_PAT - 1));

  // Next-state selection; abort outranks the normal end of RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_INIT; else state_nxt = S_IDLE;
      S_INIT:    if (abort) state_nxt = S_IDLE; else state_nxt = S_RUN;
      S_RUN: begin
        if (abort)         state_nxt = S_IDLE;
        else if (pat_last) state_nxt = S_COMPARE;
        else               state_nxt = S_RUN;
      end
      S_COMPARE: state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_INIT; else state_nxt = S_DONE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, Moore strobes (registered from the next state), counters and verdict.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state    <= S_IDLE;
      seed_ld  <= 1'b0;
      sisr_clr <= 1'b0;
      lfsr_en  <= 1'b0;
      sisr_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      pat_cnt  <= 8'd0;
      fail_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      seed_ld  <= (state_nxt == S_INIT);
      sisr_clr <= (state_nxt == S_INIT);
      lfsr_en  <= (state_nxt == S_RUN);
      sisr_en  <= (state_nxt == S_RUN);
      busy     <= (state_nxt == S_INIT) || (state_nxt == S_RUN) || (state_nxt == S_COMPARE);
      done     <= (state_nxt == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pat_cnt <= 8'd0;
            pass    <= 1'b0;
            fail    <= 1'b0;
          end else begin
            pat_cnt <= pat_cnt;
          end
        end
        S_INIT: begin
          if (abort) begin
            pass <= 1'b0;
            fail <= 1'b0;
          end else begin
            pat_cnt <= pat_cnt;
          end
        end
        S_RUN: begin
          // The pattern of this cycle was applied even if the run is aborted.
          pat_cnt <= pat_cnt + 8'd1;
          if (abort) begin
            pass <= 1'b0;
            fail <= 1'b0;
          end else begin
            pass <= pass;
          end
        end
        S_COMPARE: begin
          pass <= (sig_in == GOLDEN);
          fail <= (sig_in != GOLDEN);
          if ((sig_in != GOLDEN) && (fail_cnt != 8'd255)) begin
            fail_cnt <= fail_cnt + 8'd1;
          end else begin
            fail_cnt <= fail_cnt;
          end
        end
        default: begin
          pat_cnt <= pat_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl: default instance plus an N_PAT=1 instance for saturation.
module tb_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] sig_in = 4'h0;
  logic       seed_ld, sisr_clr, lfsr_en, sisr_en, busy, done, pass, fail;
  logic [7:0] pat_cnt, fail_cnt;

  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic [3:0] sig_in1 = 4'h3;
  logic       seed_ld1, sisr_clr1, lfsr_en1, sisr_en1, busy1, done1, pass1, fail1;
  logic [7:0] pat_cnt1, fail_cnt1;

  int vectors = 0;
  int errs    = 0;
  int mfc     = 0;
  int mfc1    = 0;

  typedef struct {
    logic       p;
    logic       f;
    logic [7:0] pc;
    logic [7:0] fc;
  } exp_t;
  exp_t sb[$];

  bist_ctrl dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .sig_in(sig_in),
    .seed_ld(seed_ld), .sisr_clr(sisr_clr), .lfsr_en(lfsr_en), .sisr_en(sisr_en),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .pat_cnt(pat_cnt), .fail_cnt(fail_cnt)
  );

  bist_ctrl #(.N_PAT(1)) dut1 (
    .clk(clk), .rst_b(rst_b), .start(start1), .abort(abort1), .sig_in(sig_in1),
    .seed_ld(seed_ld1), .sisr_clr(sisr_clr1), .lfsr_en(lfsr_en1), .sisr_en(sisr_en1),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1),
    .pat_cnt(pat_cnt1), .fail_cnt(fail_cnt1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_seed"}, seed_ld, 0);
    chk({tag, "_clr"},  sisr_clr, 0);
    chk({tag, "_lfsr"}, lfsr_en, 0);
    chk({tag, "_sisr"}, sisr_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_pat"},  pat_cnt, 0);
    chk({tag, "_fcnt"}, fail_cnt, 0);
  endtask

  // One full run on the default instance; a start pulse mid-RUN must be ignored.
  task automatic run_main(input string tag, input logic [3:0] sig);
    int   cyc;
    int   en_cnt;
    exp_t e;
    sig_in = sig;
    if (sig != 4'hA && mfc < 255) mfc++;
    sb.push_back('{p: (sig == 4'hA), f: (sig != 4'hA), pc: 8'd31, fc: 8'(mfc)});
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    en_cnt = 0;
    chk({tag, "_init_seed"}, seed_ld, 1);
    chk({tag, "_init_clr"},  sisr_clr, 1);
    chk({tag, "_init_busy"}, busy, 1);
    chk({tag, "_init_lfsr"}, lfsr_en, 0);
    while (!done && cyc < 200) begin
      start = (cyc == 8);
      tick();
      cyc++;
      if (lfsr_en && sisr_en) en_cnt++;
      if (seed_ld) en_cnt += 1000;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, 34);
    chk({tag, "_en_cycles"}, en_cnt, 31);
    e = sb.pop_front();
    chk({tag, "_pass"}, pass, e.p);
    chk({tag, "_fail"}, fail, e.f);
    chk({tag, "_pat"},  pat_cnt, e.pc);
    chk({tag, "_fcnt"}, fail_cnt, e.fc);
    chk({tag, "_busy"}, busy, 0);
    tick();
    tick();
    chk({tag, "_hold_done"}, done, 1);
    chk({tag, "_hold_pass"}, pass, e.p);
    chk({tag, "_hold_pat"},  pat_cnt, e.pc);
  endtask

  initial begin
    int   cyc;
    int   en1;
    exp_t e;

    // Reset held two cycles with start asserted.
    rst_b = 1'b1;
    start = 1'b1;
    start1 = 1'b1;
    tick();
    tick();
    chk_all_zero("rst");
    start = 1'b0;
    start1 = 1'b0;
    tick();
    rst_b = 1'b0;
    tick();
    chk("rst_no_init_busy", busy, 0);
    chk("rst_no_init_seed", seed_ld, 0);

    run_main("pass_run", 4'hA);
    run_main("fail_run1", 4'h3);
    run_main("fail_run2", 4'h3);

    // Abort in the 10th RUN cycle, with a start pulse during RUN.
    sig_in = 4'hA;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      start = (i == 5);
      tick();
    end
    start = 1'b0;
    chk("abort_pre_lfsr", lfsr_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_lfsr", lfsr_en, 0);
    chk("abort_sisr", sisr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_fail", fail, 0);
    chk("abort_pat",  pat_cnt, 10);
    chk("abort_fcnt", fail_cnt, mfc);
    tick();
    tick();
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_pat", pat_cnt, 10);

    // Reset in the 5th RUN cycle clears everything including fail_cnt.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk("midrst_pre_busy", busy, 1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    mfc = 0;
    chk_all_zero("midrst");

    // N_PAT=1 instance: 256 failing runs, fail_cnt saturates at 255.
    for (int r = 0; r < 256; r++) begin
      if (mfc1 < 255) mfc1++;
      sb.push_back('{p: 1'b0, f: 1'b1, pc: 8'd1, fc: 8'(mfc1)});
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      cyc = 1;
      en1 = 0;
      while (!done1 && cyc < 50) begin
        tick();
        cyc++;
        if (lfsr_en1) en1++;
      end
      e = sb.pop_front();
      if (r == 0 || r == 255) begin
        chk("np1_latency", cyc, 4);
        chk("np1_run_len", en1, 1);
        chk("np1_pass", pass1, e.p);
        chk("np1_fail", fail1, e.f);
        chk("np1_pat",  pat_cnt1, e.pc);
      end
      chk("np1_fcnt", fail_cnt1, e.fc);
    end
    chk("np1_sat", fail_cnt1, 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
